// File: rtl/pipe_seg_skid_pkg.sv
// pipe_seg_skid_pkg
//   Shared definitions for the pipeline segment register: the occupancy
//   state encoding used by the skid-buffer control FSM and a helper that
//   maps a state onto the occupancy count.
package pipe_seg_skid_pkg;

  // Encoding equals the number of held entries, so the state register can
  // drive the occupancy output directly.
  typedef enum logic [1:0] {
    PS_EMPTY = 2'd0,
    PS_ONE   = 2'd1,
    PS_FULL  = 2'd2
  } ps_state_e;

  function automatic logic [1:0] ps_occupancy(input ps_state_e s);
    return s;
  endfunction

endpackage

// File: rtl/pipe_seg_skid_if.sv
// pipe_seg_skid_if
//   One direction of a valid/ready stream carrying an opaque WIDTH-bit
//   payload.
//   master: drives valid/data, samples ready (producer side)
//   slave : samples valid/data, drives ready (consumer side)
interface pipe_seg_skid_if #(
  parameter int WIDTH = 32
);
  logic             valid;
  logic             ready;
  logic [WIDTH-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/pipe_seg_skid_reg.sv
// pipe_reg
//   WIDTH-wide payload register used for the main and skid entries.
//   Ports:
//     clk   in   clock
//     clr   in   synchronous clear (always honoured)
//     zclr  in   bubble clear, only honoured when ZERO_BUBBLE=1
//     load  in   load enable
//     d     in   next payload
//     q     out  stored payload
module pipe_reg #(
  parameter int WIDTH       = 32,
  parameter bit ZERO_BUBBLE = 1'b1
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             zclr,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (clr) begin
      q <= '0;
    end else if (ZERO_BUBBLE && zclr) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pipe_seg_skid.sv
// pipe_seg_skid
//   Inter-stage pipeline register with valid/ready handshake, hold (stall)
//   and flush. SKID=1 adds a second entry so in_ready comes straight from
//   the state register; SKID=0 is a single entry with a combinational
//   ready path.
//   Ports:
//     clk        in   clock
//     reset      in   synchronous active-high reset
//     hold       in   freeze: no accept, no emit, state unchanged
//     flush      in   discard all held entries
//     up         slave  upstream stream (in_valid/in_ready/in_data)
//     dn         master downstream stream (out_valid/out_ready/out_data)
//     occupancy  out  number of held entries (0..2)
module pipe_seg_skid
  import pipe_seg_skid_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter bit SKID        = 1'b1,
  parameter bit ZERO_BUBBLE = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  hold,
  input  logic                  flush,
  pipe_seg_skid_if.slave        up,
  pipe_seg_skid_if.master       dn,
  output logic [1:0]            occupancy
);

  logic             stall;
  logic             in_ready;
  logic             out_valid;
  logic             accept;
  logic             emit;
  logic             m_load;
  logic             m_zclr;
  logic [WIDTH-1:0] m_d;
  logic [WIDTH-1:0] m_q;

  // Flush outranks hold, but both block the handshake in either direction.
  assign stall     = hold | flush;
  assign accept    = up.valid & in_ready;
  assign emit      = out_valid & dn.ready;

  assign up.ready  = in_ready;
  assign dn.valid  = out_valid;
  assign dn.data   = m_q;

  generate
    if (SKID) begin : g_skid
      ps_state_e        state_reg;
      ps_state_e        state_next;
      logic             s_load;
      logic             s_zclr;
      logic             m_from_s;
      logic [WIDTH-1:0] s_q;

      always_ff @(posedge clk) begin
        if (reset) begin
          state_reg <= PS_EMPTY;
        end else begin
          state_reg <= state_next;
        end
      end

      // M always holds the oldest entry; S only ever holds the second one.
      always_comb begin
        state_next = state_reg;
        m_load     = 1'b0;
        m_zclr     = 1'b0;
        m_from_s   = 1'b0;
        s_load     = 1'b0;
        s_zclr     = 1'b0;
        if (flush) begin
          state_next = PS_EMPTY;
          m_zclr     = 1'b1;
          s_zclr     = 1'b1;
        end else begin
          // Under hold accept and emit are both 0, so nothing moves.
          case (state_reg)
            PS_EMPTY: begin
              if (accept) begin
                state_next = PS_ONE;
                m_load     = 1'b1;
              end
            end
            PS_ONE: begin
              if (accept && emit) begin
                m_load = 1'b1;
              end else if (accept) begin
                state_next = PS_FULL;
                s_load     = 1'b1;
              end else if (emit) begin
                state_next = PS_EMPTY;
                m_zclr     = 1'b1;
              end
            end
            PS_FULL: begin
              // in_ready is 0 here, so only the skid entry can advance.
              if (emit) begin
                state_next = PS_ONE;
                m_load     = 1'b1;
                m_from_s   = 1'b1;
                s_zclr     = 1'b1;
              end
            end
            default: begin
              state_next = PS_EMPTY;
            end
          endcase
        end
      end

      // Ready depends on state, hold and flush only: no out_ready term.
      assign in_ready  = (state_reg != PS_FULL) & ~stall;
      assign out_valid = (state_reg != PS_EMPTY) & ~stall;
      assign m_d       = m_from_s ? s_q : up.data;
      assign occupancy = ps_occupancy(state_reg);

      pipe_reg #(
        .WIDTH       (WIDTH),
        .ZERO_BUBBLE (ZERO_BUBBLE)
      ) u_s (
        .clk  (clk),
        .clr  (reset),
        .zclr (s_zclr),
        .load (s_load),
        .d    (up.data),
        .q    (s_q)
      );
    end else begin : g_single
      logic v_reg;

      always_ff @(posedge clk) begin
        if (reset || flush) begin
          v_reg <= 1'b0;
        end else if (accept) begin
          v_reg <= 1'b1;
        end else if (emit) begin
          v_reg <= 1'b0;
        end
      end

      // The entry drains only when it leaves without being replaced.
      always_comb begin
        m_load = accept;
        m_zclr = flush | (emit & ~accept);
      end

      assign in_ready  = (~v_reg | dn.ready) & ~stall;
      assign out_valid = v_reg & ~stall;
      assign m_d       = up.data;
      assign occupancy = {1'b0, v_reg};
    end
  endgenerate

  pipe_reg #(
    .WIDTH       (WIDTH),
    .ZERO_BUBBLE (ZERO_BUBBLE)
  ) u_m (
    .clk  (clk),
    .clr  (reset),
    .zclr (m_zclr),
    .load (m_load),
    .d    (m_d),
    .q    (m_q)
  );

endmodule

// File: tb/tb_pipe_seg_skid.sv
// tb_pipe_seg_skid
//   Two instances side by side: index 0 is SKID=1, index 1 is SKID=0, both
//   ZERO_BUBBLE=1. Each has a queue model (capacity 2 or 1) checked every
//   cycle on the falling edge; directed sequences pin the model with
//   literal expectations, then a randomized phase exercises everything.
module tb_pipe_seg_skid;

  localparam int W = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset;
  logic [1:0]   hold, flush, in_valid, out_ready;
  logic [W-1:0] in_data [2];
  logic [1:0]   dut_ready, dut_valid;
  logic [W-1:0] dut_data [2];
  logic [1:0]   dut_occ [2];

  int total = 0;
  int bad   = 0;

  logic [W-1:0] got0[$];
  logic [W-1:0] got1[$];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
      localparam bit SK = (gi == 0);

      pipe_seg_skid_if #(.WIDTH(W)) up_if ();
      pipe_seg_skid_if #(.WIDTH(W)) dn_if ();
      logic [1:0] occ;

      assign up_if.valid   = in_valid[gi];
      assign up_if.data    = in_data[gi];
      assign dn_if.ready   = out_ready[gi];
      assign dut_ready[gi] = up_if.ready;
      assign dut_valid[gi] = dn_if.valid;
      assign dut_data[gi]  = dn_if.data;
      assign dut_occ[gi]   = occ;

      pipe_seg_skid #(
        .WIDTH       (W),
        .SKID        (SK),
        .ZERO_BUBBLE (1'b1)
      ) dut (
        .clk       (clk),
        .reset     (reset),
        .hold      (hold[gi]),
        .flush     (flush[gi]),
        .up        (up_if),
        .dn        (dn_if),
        .occupancy (occ)
      );

      // Behavioural model: a FIFO of the held beats, oldest at the front.
      logic [W-1:0] q[$];

      initial begin : model
        int           sz;
        logic         e_rdy, e_val, acc, em, clr;
        logic [W-1:0] e_data, din;
        @(posedge clk);
        forever begin
          @(negedge clk);
          sz     = q.size();
          e_rdy  = (SK ? (sz < 2) : (sz == 0 || out_ready[gi])) && !hold[gi] && !flush[gi];
          e_val  = (sz > 0) && !hold[gi] && !flush[gi];
          e_data = (sz > 0) ? q[0] : '0;
          check($sformatf("d%0d_in_ready", gi), W'(dut_ready[gi]), W'(e_rdy));
          check($sformatf("d%0d_out_valid", gi), W'(dut_valid[gi]), W'(e_val));
          check($sformatf("d%0d_out_data", gi), dut_data[gi], e_data);
          check($sformatf("d%0d_occupancy", gi), W'(dut_occ[gi]), W'(sz));
          if (dut_valid[gi] && out_ready[gi]) begin
            if (SK) got0.push_back(dut_data[gi]);
            else    got1.push_back(dut_data[gi]);
          end
          acc = in_valid[gi] && e_rdy;
          em  = e_val && out_ready[gi];
          clr = reset || flush[gi];
          din = in_data[gi];
          @(posedge clk);
          if (clr) begin
            q.delete();
          end else begin
            if (em)  void'(q.pop_front());
            if (acc) q.push_back(din);
          end
        end
      end
    end
  endgenerate

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present d on port k and return just after the edge that accepts it.
  task automatic send(input int k, input logic [W-1:0] d);
    int n;
    in_valid[k] = 1'b1;
    in_data[k]  = d;
    n = 0;
    while (1) begin
      @(negedge clk);
      if (dut_ready[k]) break;
      n++;
      if (n > 50) begin
        total++;
        bad++;
        $display("FAIL send_timeout d%0d data=%0h: in_ready stayed 0, wanted 1", k, d);
        break;
      end
    end
    tick();
  endtask

  task automatic wait_drain(input int k);
    int n;
    n = 0;
    while (1) begin
      @(negedge clk);
      if (dut_occ[k] == 2'd0) break;
      n++;
      if (n > 50) begin
        total++;
        bad++;
        $display("FAIL drain_timeout d%0d: occupancy %0d, wanted 0", k, dut_occ[k]);
        break;
      end
    end
    tick();
  endtask

  task automatic check_list(input string name, input logic [W-1:0] act[$], input logic [W-1:0] exp[$]);
    check({name, "_count"}, W'(act.size()), W'(exp.size()));
    for (int i = 0; i < exp.size(); i++) begin
      check($sformatf("%s_%0d", name, i), (i < act.size()) ? act[i] : 'x, exp[i]);
    end
  endtask

  initial begin : stim
    logic [W-1:0] exp[$];
    int thr;

    reset     = 1'b1;
    hold      = 2'b00;
    flush     = 2'b00;
    in_valid  = 2'b11;
    out_ready = 2'b00;
    in_data[0] = 32'hDEADBEEF;
    in_data[1] = 32'hDEADBEEF;

    // Reset held three cycles with a beat offered.
    tick();
    tick();
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check($sformatf("rst_valid_d%0d", k), W'(dut_valid[k]), 0);
      check($sformatf("rst_occ_d%0d", k), W'(dut_occ[k]), 0);
      check($sformatf("rst_data_d%0d", k), dut_data[k], 0);
    end
    tick();
    reset    = 1'b0;
    in_valid = 2'b00;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check($sformatf("post_rst_ready_d%0d", k), W'(dut_ready[k]), 1);
    end
    tick();

    // Streaming through the skid variant.
    out_ready[0] = 1'b1;
    got0.delete();
    for (int i = 1; i <= 8; i++) send(0, W'(i));
    in_valid[0] = 1'b0;
    wait_drain(0);
    exp = {32'h1, 32'h2, 32'h3, 32'h4, 32'h5, 32'h6, 32'h7, 32'h8};
    check_list("stream", got0, exp);

    // Backpressure: two entries fill the skid, third waits upstream.
    out_ready[0] = 1'b0;
    got0.delete();
    send(0, 32'hA);
    send(0, 32'hB);
    in_data[0] = 32'hC;
    @(negedge clk);
    check("bp_occ", W'(dut_occ[0]), 2);
    check("bp_ready", W'(dut_ready[0]), 0);
    tick();
    @(negedge clk);
    check("bp_ready_hold", W'(dut_ready[0]), 0);
    check("bp_head", dut_data[0], 32'hA);
    tick();
    out_ready[0] = 1'b1;
    send(0, 32'hC);
    in_valid[0] = 1'b0;
    wait_drain(0);
    exp = {32'hA, 32'hB, 32'hC};
    check_list("bp", got0, exp);

    // Flush while full, with a beat offered in the same cycle.
    out_ready[0] = 1'b0;
    got0.delete();
    send(0, 32'h11);
    send(0, 32'h22);
    in_data[0] = 32'h33;
    flush[0]   = 1'b1;
    @(negedge clk);
    check("flush_ready", W'(dut_ready[0]), 0);
    tick();
    flush[0]     = 1'b0;
    out_ready[0] = 1'b1;
    @(negedge clk);
    check("flush_occ", W'(dut_occ[0]), 0);
    check("flush_valid", W'(dut_valid[0]), 0);
    check("flush_data", dut_data[0], 0);
    tick();
    in_valid[0] = 1'b0;
    wait_drain(0);
    exp = {32'h33};
    check_list("flush", got0, exp);

    // Hold for four cycles with one entry waiting.
    out_ready[0] = 1'b0;
    got0.delete();
    send(0, 32'h55);
    in_valid[0]  = 1'b0;
    hold[0]      = 1'b1;
    out_ready[0] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("hold_valid_%0d", i), W'(dut_valid[0]), 0);
      check($sformatf("hold_ready_%0d", i), W'(dut_ready[0]), 0);
      tick();
    end
    hold[0] = 1'b0;
    wait_drain(0);
    exp = {32'h55};
    check_list("hold", got0, exp);

    // Single-register variant with a toggling out_ready.
    got1.delete();
    out_ready[1] = 1'b1;
    send(1, 32'h1);
    out_ready[1] = 1'b0;
    in_data[1]   = 32'h2;
    @(negedge clk);
    check("s0_ready_blocked", W'(dut_ready[1]), 0);
    tick();
    out_ready[1] = 1'b1;
    @(negedge clk);
    check("s0_ready_comb", W'(dut_ready[1]), 1);
    check("s0_occ", W'(dut_occ[1]), 1);
    tick();
    send(1, 32'h3);
    in_valid[1] = 1'b0;
    wait_drain(1);
    exp = {32'h1, 32'h2, 32'h3};
    check_list("s0", got1, exp);

    // Randomized phase, three out_ready densities.
    for (int ph = 0; ph < 3; ph++) begin
      thr = (ph == 0) ? 8 : ((ph == 1) ? 5 : 2);
      for (int c = 0; c < 1000; c++) begin
        for (int k = 0; k < 2; k++) begin
          in_valid[k]  = ($urandom % 4) != 0;
          in_data[k]   = $urandom;
          out_ready[k] = ($urandom % 8) < thr;
          hold[k]      = ($urandom % 16) == 0;
          flush[k]     = ($urandom % 40) == 0;
        end
        reset = ($urandom % 250) == 0;
        tick();
      end
    end

    reset     = 1'b0;
    in_valid  = 2'b00;
    hold      = 2'b00;
    flush     = 2'b00;
    out_ready = 2'b11;
    tick();
    tick();
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
